// File: rtl/mm_run_sequencer.sv
// Run sequencer for the matrix-multiplication array: IDLE -> LOAD -> RUN -> TX -> FIN.
// Optional RUN-phase watchdog enabled by defining MM_SEQ_WATCHDOG_EN.
module mm_run_sequencer #(
  parameter int N_CORES = 4,
  parameter int CW      = 32,
  parameter int TIMEOUT = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_CORES-1:0] core_mask,
  input  logic               abort,
  input  logic               load_done,
  input  logic [N_CORES-1:0] end_process,
  input  logic               tx_done,
  output logic [1:0]         status,
  output logic               tx_start,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [CW-1:0]      cycle_count
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_TX, S_FIN} state_t;

  state_t               r_state;
  state_t               w_state_d;
  logic   [1:0]         r_status;
  logic                 r_tx_start;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_error;
  logic   [CW-1:0]      r_cycle_count;
  logic   [N_CORES-1:0] r_active_mask;
  logic   [N_CORES-1:0] r_done_mask;
  logic   [N_CORES-1:0] w_fin_mask;
  logic                 w_exit;
  logic                 w_timeout;
  logic                 w_err;

  function automatic logic [1:0] status_of(input state_t s);
    case (s)
      S_LOAD:  return 2'b10;
      S_RUN:   return 2'b01;
      S_TX:    return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // A core finishing on this very cycle counts toward the exit decision.
  assign w_fin_mask = r_done_mask | (end_process & r_active_mask);
  assign w_exit     = (w_fin_mask == r_active_mask);

`ifdef MM_SEQ_WATCHDOG_EN
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  assign w_timeout = (r_cycle_count == TMO_LAST);
`else
  assign w_timeout = 1'b0 && (TIMEOUT > 0);
`endif

  always_comb begin
    w_state_d = r_state;
    w_err     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (|core_mask) w_state_d = S_LOAD;
          else            w_err     = 1'b1;
        end
      end
      S_LOAD: begin
        if (abort) begin
          w_state_d = S_IDLE;
          w_err     = 1'b1;
        end else if (load_done) begin
          w_state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_d = S_IDLE;
          w_err     = 1'b1;
        end else if (w_exit) begin
          w_state_d = S_TX;
        end else if (w_timeout) begin
          w_state_d = S_IDLE;
          w_err     = 1'b1;
        end
      end
      S_TX: begin
        if (abort) begin
          w_state_d = S_IDLE;
          w_err     = 1'b1;
        end else if (tx_done) begin
          w_state_d = S_FIN;
        end
      end
      S_FIN:   w_state_d = S_IDLE;
      default: w_state_d = S_IDLE;
    endcase
  end

  // Outputs are derived from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_status      <= 2'b00;
      r_tx_start    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_cycle_count <= '0;
      r_active_mask <= '0;
      r_done_mask   <= '0;
    end else begin
      r_state    <= w_state_d;
      r_status   <= status_of(w_state_d);
      r_tx_start <= (r_state == S_RUN) && (w_state_d == S_TX);
      r_busy     <= (w_state_d == S_LOAD) || (w_state_d == S_RUN) || (w_state_d == S_TX);
      r_done     <= (w_state_d == S_FIN);
      r_error    <= w_err;
      if ((r_state == S_IDLE) && (w_state_d == S_LOAD)) begin
        r_active_mask <= core_mask;
        r_done_mask   <= '0;
        r_cycle_count <= '0;
      end else if (r_state == S_RUN) begin
        r_done_mask   <= w_fin_mask;
        r_cycle_count <= sat_inc(r_cycle_count);
      end
    end
  end

  assign status      = r_status;
  assign tx_start    = r_tx_start;
  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;
  assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_mm_run_sequencer.sv
// Self-checking bench for mm_run_sequencer: phase-level reference model plus directed runs.
module tb_mm_run_sequencer;

  localparam int NC  = 4;
  localparam int TMO = 20;

  logic          clk;
  logic          rst;
  logic          start;
  logic [NC-1:0] core_mask;
  logic          abort;
  logic          load_done;
  logic [NC-1:0] end_process;
  logic          tx_done;
  logic [1:0]    status;
  logic          tx_start;
  logic          busy;
  logic          done;
  logic          error;
  logic [31:0]   cycle_count;

  mm_run_sequencer #(.N_CORES(NC), .CW(32), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .core_mask   (core_mask),
    .abort       (abort),
    .load_done   (load_done),
    .end_process (end_process),
    .tx_done     (tx_done),
    .status      (status),
    .tx_start    (tx_start),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_tx   = 0;
  int n_done = 0;
  int n_err  = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: which phase the run is in, and the run bookkeeping.
  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_TX = 3, P_FIN = 4;
  int          ph;
  logic [NC-1:0] m_amask, m_dmask;
  int unsigned m_cnt, m_prev;
  bit          m_tx, m_done, m_err;

  function automatic int phase_status(input int p);
    case (p)
      P_LOAD:  return 2;
      P_RUN:   return 1;
      P_TX:    return 3;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = P_IDLE; m_amask = '0; m_dmask = '0; m_cnt = 0;
      m_tx = 0; m_done = 0; m_err = 0;
    end else begin
      m_tx = 0; m_done = 0; m_err = 0;
      m_prev = m_cnt;
      case (ph)
        P_IDLE: if (start) begin
          if (core_mask != '0) begin
            m_amask = core_mask; m_dmask = '0; m_cnt = 0; ph = P_LOAD;
          end else m_err = 1;
        end
        P_LOAD: if (abort) begin ph = P_IDLE; m_err = 1; end
                else if (load_done) ph = P_RUN;
        P_RUN: begin
          if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
          m_dmask = m_dmask | (end_process & m_amask);
          if (abort) begin ph = P_IDLE; m_err = 1; end
          else if (m_dmask == m_amask) begin ph = P_TX; m_tx = 1; end
`ifdef MM_SEQ_WATCHDOG_EN
          else if (m_prev == TMO - 1) begin ph = P_IDLE; m_err = 1; end
`endif
        end
        P_TX: if (abort) begin ph = P_IDLE; m_err = 1; end
              else if (tx_done) begin ph = P_FIN; m_done = 1; end
        default: ph = P_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("status",      status,      phase_status(ph));
    chk("busy",        busy,        (ph == P_LOAD || ph == P_RUN || ph == P_TX));
    chk("tx_start",    tx_start,    m_tx);
    chk("done",        done,        m_done);
    chk("error",       error,       m_err);
    chk("cycle_count", cycle_count, m_cnt);
    n_tx   += int'(tx_start);
    n_done += int'(done);
    n_err  += int'(error);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  int d0, t0, e0;

  initial begin
    rst = 1'b1; start = 0; core_mask = '0; abort = 0;
    load_done = 0; end_process = '0; tx_done = 0;
    step(2);
    chk("rst_status", status, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", cycle_count, 0);
    rst = 1'b0;
    step(1);

    // Nominal run, cores 0 and 1
    d0 = n_done; t0 = n_tx;
    core_mask = 4'b0011; start = 1;
    step(1); start = 0;
    chk("nom_load_status", status, 2);
    chk("nom_busy", busy, 1);
    step(2); load_done = 1;
    step(1); load_done = 0;
    chk("nom_run_status", status, 1);
    step(10); end_process = 4'b0001;
    step(4);  end_process = 4'b0011;
    step(1);  end_process = 4'b0000;
    chk("nom_tx_status", status, 3);
    chk("nom_tx_start", tx_start, 1);
    chk("nom_count", cycle_count, 15);
    tx_done = 1;
    step(1); tx_done = 0;
    chk("nom_done", done, 1);
    chk("nom_fin_busy", busy, 0);
    step(2);
    chk("nom_done_pulses", n_done - d0, 1);
    chk("nom_tx_pulses", n_tx - t0, 1);
    chk("nom_count_hold", cycle_count, 15);

    // Masked core: end_process[0] ignored
    core_mask = 4'b0100; end_process = 4'b0001; start = 1;
    step(1); start = 0; load_done = 1;
    step(1); load_done = 0;
    step(4);
    chk("mask_still_run", status, 1);
    step(2); end_process = 4'b0101;
    step(1); end_process = 4'b0000;
    chk("mask_tx", status, 3);
    chk("mask_count", cycle_count, 7);
    tx_done = 1;
    step(1); tx_done = 0;
    step(2);

    // Empty mask
    e0 = n_err;
    core_mask = 4'b0000; start = 1;
    step(1); start = 0;
    chk("empty_error", error, 1);
    chk("empty_busy", busy, 0);
    chk("empty_status", status, 0);
    step(2);
    chk("empty_err_pulses", n_err - e0, 1);

    // Abort in the 5th RUN cycle
    core_mask = 4'b0001; start = 1;
    step(1); start = 0; load_done = 1;
    step(1); load_done = 0;
    step(4); abort = 1;
    step(1); abort = 0;
    chk("abort_status", status, 0);
    chk("abort_busy", busy, 0);
    chk("abort_error", error, 1);
    chk("abort_count", cycle_count, 5);
    step(3);
    chk("abort_frozen", cycle_count, 5);
    core_mask = 4'b0010; start = 1;
    step(1); start = 0;
    chk("restart_count", cycle_count, 0);
    chk("restart_status", status, 2);
    abort = 1;
    step(1); abort = 0;
    step(1);

    // Asynchronous reset in the first TX cycle
    d0 = n_done;
    core_mask = 4'b0001; start = 1;
    step(1); start = 0; load_done = 1;
    step(1); load_done = 0; end_process = 4'b0001;
    step(1); end_process = 4'b0000;
    chk("art_tx_start", tx_start, 1);
    #2 rst = 1'b1;
    #1;
    chk("art_status_now", status, 0);
    chk("art_tx_start_now", tx_start, 0);
    chk("art_busy_now", busy, 0);
    #1 rst = 1'b0;
    tx_done = 1;
    step(3); tx_done = 0;
    chk("art_no_done", n_done - d0, 0);

    // Watchdog window: no core ever finishes
    e0 = n_err;
    core_mask = 4'b0001; start = 1;
    step(1); start = 0; load_done = 1;
    step(1); load_done = 0;
    step(20);
    chk("wd_count", cycle_count, 20);
`ifdef MM_SEQ_WATCHDOG_EN
    chk("wd_status", status, 0);
    chk("wd_error", error, 1);
    chk("wd_busy", busy, 0);
`else
    chk("wd_status", status, 1);
    chk("wd_error", n_err - e0, 0);
    abort = 1;
    step(1); abort = 0;
`endif
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mm_run_sequencer.md
Name: mm_run_sequencer

Overview:
Top-level run sequencer for the matrix-multiplication processor array. It takes one host start request through the load, compute and transmit phases. It drives the shared 2-bit status bus that each core control unit samples in its idle state. It collects per-core end_process levels and counts compute cycles for performance readback.

Parameters:
N_CORES, 4, number of processor cores (control units) sequenced
CW, 32, width of the compute-cycle counter
TIMEOUT, 1000000, watchdog limit in RUN cycles (used only with the optional feature)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  host run request, sampled in IDLE only
core_mask  input  N_CORES  cores taking part in this run, latched at start
abort  input  1  host abort, honoured in LOAD/RUN/TX
load_done  input  1  level; instruction/data memories loaded
end_process  input  N_CORES  per-core level, high while that core sits in its end state
tx_done  input  1  result transmitter finished
status  output  2  core status bus: 00 idle, 10 load, 01 run, 11 transmit
tx_start  output  1  one-cycle pulse to start result transmission
busy  output  1  high from start acceptance until return to IDLE
done  output  1  one-cycle pulse on successful completion
error  output  1  one-cycle pulse on rejected start, abort or timeout
cycle_count  output  CW  number of cycles spent in RUN for the last/current run

Behaviour:
- Reset: asynchronous and active-high. While rst is high and after release, all of the following hold:
  - state=IDLE, status=00
  - tx_start=0, busy=0, done=0, error=0
  - cycle_count=0, active_mask=0, done_mask=0
  - rst mid-run drops status to 00 immediately.
- All outputs are registered.
- States are IDLE, LOAD, RUN, TX, FIN.
- IDLE: status=00.
  - start=1 with core_mask!=0: latch active_mask=core_mask, clear done_mask and cycle_count, set busy=1, go to LOAD.
  - start=1 with core_mask==0: error pulses one cycle; stay in IDLE.
- LOAD: status=10. load_done=1 -> go to RUN. load_done is ignored in every other state.
- RUN: status=01, held for the whole state.
  - done_mask <= done_mask | (end_process & active_mask) every cycle.
  - cycle_count increments every RUN cycle, including the first; it saturates at all-ones (no wrap).
  - end_process bits outside active_mask are ignored.
  - Exit when (done_mask | (end_process & active_mask)) == active_mask. A core finishing on the same cycle as the last other core counts.
  - Exit -> go to TX, with tx_start pulsed in the first TX cycle.
- TX: status=11. tx_start is high only in the first TX cycle. tx_done=1 (including in that first cycle) -> go to FIN.
- FIN: one cycle. done=1, busy=0 in that cycle, status=00, then IDLE. start in FIN is ignored.
- Abort: abort=1 in LOAD, RUN or TX takes priority over every other transition. Result: next state IDLE, status=00, busy=0, one-cycle error pulse, cycle_count frozen. Abort in IDLE or FIN is ignored.
- Holding values:
  - cycle_count holds its value outside RUN until the next accepted start.
  - start while busy is ignored, with no error.
- Latency:
  - start -> status=10: 1 cycle.
  - load_done -> status=01: 1 cycle.
  - last end_process -> status=11 and tx_start: 1 cycle.
  - tx_done -> done: 1 cycle.

Optional Feature:
Macro MM_SEQ_WATCHDOG_EN.
- Defined: in RUN, when cycle_count reaches TIMEOUT-1 and the exit condition is not met, the next state is IDLE. That transition pulses error, sets status=00 and busy=0, and does not pulse done or tx_start. Abort still has priority.
- Not defined: no timeout. RUN waits indefinitely and the TIMEOUT parameter is unused.

Test Plan:
- Nominal run: core_mask=0011, start; load_done 3 cycles later; end_process[0] rises after 10 RUN cycles, end_process[1] after 14 -> status sequence 10,01,11,00; tx_start one pulse; tx_done -> done pulse; cycle_count=15 (last-done cycle counted).
- Masked core: core_mask=0100 while end_process[0] is held high from the start -> RUN continues until end_process[2]=1; end_process[0] is ignored.
- Empty mask: start with core_mask=0000 -> error one pulse, busy stays 0, status stays 00.
- Abort mid-RUN: abort in the 5th RUN cycle -> next cycle status=00, busy=0, error one pulse, cycle_count=5 and frozen; a new start restarts with cycle_count=0.
- Async reset in TX: rst pulsed between clock edges -> status=00 and tx_start=0 immediately, without waiting for a clock edge; tx_done afterwards -> no done pulse.
- Watchdog (MM_SEQ_WATCHDOG_EN, TIMEOUT=20): no end_process -> after 20 RUN cycles error pulse, status=00, no done; without the macro, status stays 01.
